// File: rtl/i2c_irq_status_ack.sv
// Sticky I2C interrupt status with software mask, level irq, ack handshake and re-arm holdoff.
// Optional build macro I2C_IRQ_COUNT_EN adds a saturating 8-bit irq assertion counter.
module i2c_irq_status_ack #(
  parameter int                    NUM_STATUS     = 13,
  parameter logic [NUM_STATUS-1:0] MASK_RST       = 13'h006D,
  parameter int                    HOLDOFF_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STATUS-1:0] status_evt,
  input  logic                  clr_valid,
  input  logic [NUM_STATUS-1:0] clr_bits,
  input  logic                  mask_wr,
  input  logic [NUM_STATUS-1:0] mask_data,
  input  logic                  irq_ack,
  output logic [NUM_STATUS-1:0] status_q,
  output logic [NUM_STATUS-1:0] mask_q,
  output logic                  pending,
  output logic                  irq,
  output logic [7:0]            irq_count
);

  localparam int HCW = ($clog2(HOLDOFF_CYCLES + 1) > 3) ? $clog2(HOLDOFF_CYCLES + 1) : 3;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLDOFF_CYCLES);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ASSERT  = 2'd1;
  localparam logic [1:0] HOLDOFF = 2'd2;

  logic [NUM_STATUS-1:0] status_reg;
  logic [NUM_STATUS-1:0] status_next;
  logic [NUM_STATUS-1:0] mask_reg;
  logic                  pending_reg;
  logic [1:0]            state_reg;
  logic [1:0]            state_next;
  logic [HCW-1:0]        hold_cnt_reg;
  logic [HCW-1:0]        hold_cnt_next;

  // A new event on a bit overrides a W1C of that same bit in the same cycle.
  for (genvar gi = 0; gi < NUM_STATUS; gi++) begin : g_status
    assign status_next[gi] = status_evt[gi] | (status_reg[gi] & ~(clr_valid & clr_bits[gi]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_reg  <= '0;
      mask_reg    <= MASK_RST;
      pending_reg <= 1'b0;
    end else begin
      status_reg  <= status_next;
      pending_reg <= |(status_reg & mask_reg);
      if (mask_wr) begin
        mask_reg <= mask_data;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        // Ack wins over pending dropping in the same cycle.
        if (irq_ack) begin
          state_next    = HOLDOFF;
          hold_cnt_next = HOLD_LOAD;
        end else if (!pending_reg) begin
          state_next = IDLE;
        end
      end
      HOLDOFF: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg - HOLD_LAST;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

`ifdef I2C_IRQ_COUNT_EN
  logic [7:0] irq_count_reg;
  logic       count_clr;
  logic       count_inc;

  assign count_clr = clr_valid & (&clr_bits);
  assign count_inc = (state_reg == IDLE) && (state_next == ASSERT);

  // Clearing takes precedence over an assertion landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst || count_clr) begin
      irq_count_reg <= 8'h00;
    end else if (count_inc && (irq_count_reg != 8'hFF)) begin
      irq_count_reg <= irq_count_reg + 8'h01;
    end
  end

  assign irq_count = irq_count_reg;
`else
  assign irq_count = 8'h00;
`endif

  assign status_q = status_reg;
  assign mask_q   = mask_reg;
  assign pending  = pending_reg;
  assign irq      = (state_reg == ASSERT);

endmodule

// File: tb/tb_i2c_irq_status_ack.sv
// Directed bench for i2c_irq_status_ack: latency, holdoff, masking, W1C priority, reset, irq counter.
module tb_i2c_irq_status_ack;

  localparam int N = 13;
`ifdef I2C_IRQ_COUNT_EN
  localparam int         NUM_ACKS  = 300;
  localparam logic [7:0] CNT_MID   = 8'd3;
  localparam logic [7:0] CNT_FINAL = 8'hFF;
`else
  localparam int         NUM_ACKS  = 5;
  localparam logic [7:0] CNT_MID   = 8'h00;
  localparam logic [7:0] CNT_FINAL = 8'h00;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] status_evt = '0;
  logic         clr_valid = 1'b0;
  logic [N-1:0] clr_bits = '0;
  logic         mask_wr = 1'b0;
  logic [N-1:0] mask_data = '0;
  logic         irq_ack = 1'b0;
  logic [N-1:0] status_q;
  logic [N-1:0] mask_q;
  logic         pending;
  logic         irq;
  logic [7:0]   irq_count;

  int total = 0;
  int bad   = 0;

  i2c_irq_status_ack dut (
    .clk        (clk),
    .rst        (rst),
    .status_evt (status_evt),
    .clr_valid  (clr_valid),
    .clr_bits   (clr_bits),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .irq_ack    (irq_ack),
    .status_q   (status_q),
    .mask_q     (mask_q),
    .pending    (pending),
    .irq        (irq),
    .irq_count  (irq_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (status_q !== 13'h0000) begin bad++; $display("FAIL reset_status got=%h want=0000", status_q); end
    else $display("ok reset_status %h", status_q);
    total++; if (mask_q !== 13'h006D) begin bad++; $display("FAIL reset_mask got=%h want=006d", mask_q); end
    else $display("ok reset_mask %h", mask_q);
    total++; if ({pending, irq} !== 2'b00) begin bad++; $display("FAIL reset_pend_irq got=%b%b want=00", pending, irq); end
    else $display("ok reset_pend_irq %b%b", pending, irq);
    total++; if (irq_count !== 8'h00) begin bad++; $display("FAIL reset_count got=%h want=00", irq_count); end
    else $display("ok reset_count %h", irq_count);
  endtask

  task automatic test_latency();
    status_evt = 13'h0001;
    step();
    status_evt = '0;
    total++; if ({status_q, pending, irq} !== {13'h0001, 2'b00}) begin bad++;
      $display("FAIL lat_n1 got=%h/%b/%b want=0001/0/0", status_q, pending, irq); end
    else $display("ok lat_n1 %h/%b/%b", status_q, pending, irq);
    step();
    total++; if ({pending, irq} !== 2'b10) begin bad++; $display("FAIL lat_n2 got=%b%b want=10", pending, irq); end
    else $display("ok lat_n2 %b%b", pending, irq);
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL lat_n3 irq got=%b want=1", irq); end
    else $display("ok lat_n3 irq %b", irq);
    for (int k = 0; k < 4; k++) step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL lat_hold irq got=%b want=1", irq); end
    else $display("ok lat_hold irq %b", irq);
  endtask

  task automatic test_holdoff();
    int low;
    int highs;
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    low = 0;
    while (irq === 1'b0 && low < 20) begin
      low++;
      step();
    end
    total++; if (low != 5) begin bad++; $display("FAIL holdoff_low_cycles got=%0d want=5", low); end
    else $display("ok holdoff_low_cycles %0d", low);
    // W1C then ack: no re-arm afterwards
    clr_valid = 1'b1;
    clr_bits  = 13'h0001;
    step();
    clr_valid = 1'b0;
    clr_bits  = '0;
    irq_ack   = 1'b1;
    step();
    irq_ack = 1'b0;
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      if (irq !== 1'b0) highs++;
      step();
    end
    total++; if (highs != 0 || status_q !== 13'h0000) begin bad++;
      $display("FAIL clr_ack_quiet got=highs %0d status %h want=highs 0 status 0000", highs, status_q); end
    else $display("ok clr_ack_quiet highs %0d status %h", highs, status_q);
  endtask

  task automatic test_masked();
    status_evt = 13'h0002;
    step();
    status_evt = '0;
    total++; if (status_q !== 13'h0002) begin bad++; $display("FAIL masked_status got=%h want=0002", status_q); end
    else $display("ok masked_status %h", status_q);
    for (int k = 0; k < 4; k++) step();
    total++; if ({pending, irq} !== 2'b00) begin bad++; $display("FAIL masked_quiet got=%b%b want=00", pending, irq); end
    else $display("ok masked_quiet %b%b", pending, irq);
    mask_wr   = 1'b1;
    mask_data = 13'h0002;
    step();
    mask_wr = 1'b0;
    total++; if ({mask_q, irq} !== {13'h0002, 1'b0}) begin bad++;
      $display("FAIL mask_load got=%h/%b want=0002/0", mask_q, irq); end
    else $display("ok mask_load %h/%b", mask_q, irq);
    step();
    total++; if ({pending, irq} !== 2'b10) begin bad++; $display("FAIL mask_pend got=%b%b want=10", pending, irq); end
    else $display("ok mask_pend %b%b", pending, irq);
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq got=%b want=1", irq); end
    else $display("ok mask_irq %b", irq);
  endtask

  task automatic test_sw_clear();
    clr_valid = 1'b1;
    clr_bits  = 13'h0002;
    step();
    clr_valid = 1'b0;
    clr_bits  = '0;
    total++; if (status_q !== 13'h0000) begin bad++; $display("FAIL swclr_status got=%h want=0000", status_q); end
    else $display("ok swclr_status %h", status_q);
    step();
    total++; if ({pending, irq} !== 2'b01) begin bad++; $display("FAIL swclr_pend got=%b%b want=01", pending, irq); end
    else $display("ok swclr_pend %b%b", pending, irq);
    step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL swclr_idle irq got=%b want=0", irq); end
    else $display("ok swclr_idle irq %b", irq);
    mask_wr   = 1'b1;
    mask_data = 13'h006D;
    step();
    mask_wr = 1'b0;
  endtask

  task automatic test_set_wins();
    status_evt = 13'h0021;
    step();
    status_evt = 13'h0020;
    clr_valid  = 1'b1;
    clr_bits   = 13'h0021;
    step();
    status_evt = '0;
    clr_valid  = 1'b0;
    clr_bits   = '0;
    total++; if (status_q !== 13'h0020) begin bad++; $display("FAIL set_wins got=%h want=0020", status_q); end
    else $display("ok set_wins %h", status_q);
    clr_valid = 1'b1;
    clr_bits  = 13'h0020;
    step();
    clr_valid = 1'b0;
    clr_bits  = '0;
    for (int k = 0; k < 6; k++) step();
    total++; if ({status_q, irq} !== {13'h0000, 1'b0}) begin bad++;
      $display("FAIL set_wins_clear got=%h/%b want=0000/0", status_q, irq); end
    else $display("ok set_wins_clear %h/%b", status_q, irq);
  endtask

  task automatic test_reset_holdoff();
    int highs;
    mask_wr    = 1'b1;
    mask_data  = 13'h1FFF;
    status_evt = 13'h0001;
    step();
    mask_wr    = 1'b0;
    status_evt = '0;
    step();
    step();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rsthold_pre irq got=%b want=1", irq); end
    else $display("ok rsthold_pre irq %b", irq);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if ({status_q, mask_q, pending, irq, irq_count} !== {13'h0000, 13'h006D, 2'b00, 8'h00}) begin bad++;
      $display("FAIL rsthold_out got=%h/%h/%b/%b/%h want=0000/006d/0/0/00", status_q, mask_q, pending, irq, irq_count); end
    else $display("ok rsthold_out %h/%h/%b/%b/%h", status_q, mask_q, pending, irq, irq_count);
    highs = 0;
    for (int k = 0; k < 8; k++) begin
      if (irq !== 1'b0) highs++;
      step();
    end
    total++; if (highs != 0) begin bad++; $display("FAIL rsthold_quiet highs got=%0d want=0", highs); end
    else $display("ok rsthold_quiet highs %0d", highs);
  endtask

  task automatic test_count();
    int k;
    status_evt = 13'h0001;
    step();
    status_evt = '0;
    for (int i = 1; i <= NUM_ACKS; i++) begin
      k = 0;
      while (irq !== 1'b1 && k < 20) begin
        step();
        k++;
      end
      if (irq !== 1'b1) begin
        total++; bad++;
        $display("FAIL count_wait_irq iter=%0d got=0 want=1", i);
        break;
      end
      if (i == 3) begin
        total++; if (irq_count !== CNT_MID) begin bad++; $display("FAIL count_mid got=%h want=%h", irq_count, CNT_MID); end
        else $display("ok count_mid %h", irq_count);
      end
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
    end
    total++; if (irq_count !== CNT_FINAL) begin bad++; $display("FAIL count_final got=%h want=%h", irq_count, CNT_FINAL); end
    else $display("ok count_final %h", irq_count);
    clr_valid = 1'b1;
    clr_bits  = 13'h1FFF;
    step();
    clr_valid = 1'b0;
    clr_bits  = '0;
    total++; if ({irq_count, status_q} !== {8'h00, 13'h0000}) begin bad++;
      $display("FAIL count_clear got=%h/%h want=00/0000", irq_count, status_q); end
    else $display("ok count_clear %h/%h", irq_count, status_q);
    for (int j = 0; j < 8; j++) step();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_holdoff();
    test_masked();
    test_sw_clear();
    test_set_wins();
    test_reset_holdoff();
    test_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
